// File: rtl/uart_rx.sv
// uart_rx: UART receiver; 2-flop synchroniser, start detect, mid-bit sampling, stop check.
// Latency: valid/ferr strobe appears the cycle after the stop-bit sample edge.
// Backpressure: none; the consumer must take each byte within one frame time.
// Optional feature: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling of every bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 9,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_ferr
);

  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] C_BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    C_LAST    = 4'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, RECV, STOP, BREAK} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [3:0]              r_bit, w_bit_nxt;
  logic [PAYLOAD_BITS-1:0] r_shift, w_shift_nxt;
  logic                    w_rxd_s;
  logic                    w_sample;
  logic                    w_tick;
  logic                    w_valid_nxt;
  logic                    w_ferr_nxt;

`ifdef UART_RX_MAJORITY_EN
  // r_hist[0] is the synchronised line; r_hist[2:1] are its two previous values
  logic       r_meta;
  logic [2:0] r_hist;

  // Synchroniser plus sample history, idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_hist <= 3'b111;
    end else begin
      r_meta <= uart_rxd;
      r_hist <= {r_hist[1:0], r_meta};
    end
  end

  assign w_rxd_s  = r_hist[0];
  assign w_sample = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
`else
  logic [1:0] r_sync;

  // Two-flop synchroniser, idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], uart_rxd};
    end
  end

  assign w_rxd_s  = r_sync[1];
  assign w_sample = w_rxd_s;
`endif

  // START waits half a bit to land mid start-bit; every later sample is one full bit on
  assign w_tick = (r_state == START) ? (r_cnt == C_HALF_M1) : (r_cnt == C_BIT_M1);

  // Next-state, counters, shift register and strobe decisions
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (!w_rxd_s && uart_rx_en) w_state_nxt = START;
      end
      START: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          // a high start sample means the fall was a glitch
          w_state_nxt = w_sample ? IDLE : RECV;
        end
      end
      RECV: begin
        if (w_tick) begin
          w_cnt_nxt                   = '0;
          w_shift_nxt                 = r_shift >> 1;
          w_shift_nxt[PAYLOAD_BITS-1] = w_sample;
          if (r_bit == C_LAST) w_state_nxt = STOP;
          else                 w_bit_nxt   = r_bit + 4'd1;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (w_sample) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        // a held-low line must return high before a new start can be seen
        w_cnt_nxt = '0;
        if (w_rxd_s) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_bit         <= '0;
      r_shift       <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_ferr  <= 1'b0;
      uart_rx_data  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_bit         <= w_bit_nxt;
      r_shift       <= w_shift_nxt;
      uart_rx_valid <= w_valid_nxt;
      uart_rx_ferr  <= w_ferr_nxt;
      if (w_valid_nxt) uart_rx_data <= r_shift;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: builds a per-cycle line/enable/reset script, predicts strobes by frame search,
// then replays the script into uart_rx and compares its outputs every cycle.
module tb_uart_rx;

  localparam int CPB  = 9;
  localparam int PB   = 8;
  localparam int HALF = CPB / 2;
  localparam int N    = 9000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_en = 1'b0;
  logic       uart_rx_valid;
  logic       uart_rx_ferr;
  logic [7:0] uart_rx_data;

  uart_rx #(.CLKS_PER_BIT(CPB), .PAYLOAD_BITS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_ferr(uart_rx_ferr)
  );

  always #5 clk = ~clk;

  // Interval i = time between posedge i and posedge i+1; inputs for interval i are
  // applied just after posedge i and first sampled at posedge i+1.
  bit         s_line[N], s_en[N], s_rst[N];
  bit         ev_v[N], ev_f[N];
  logic [7:0] ev_d[N];
  bit         e_valid[N], e_ferr[N];
  logic [7:0] e_data[N];
  bit         d_valid[N], d_ferr[N];
  logic [7:0] d_data[N];

  int len = 0;
  bit cur_en = 1'b0, cur_rst = 1'b1;
  int errors = 0, checks = 0, fail_prints = 0;
  int m_idle, m_a5, m_00, m_55, m_short, m_3c1, m_rf, m_3c2, m_f0;

  task automatic put(input bit v, input int n);
    for (int j = 0; j < n; j++) begin
      if (len < N) begin
        s_line[len] = v; s_en[len] = cur_en; s_rst[len] = cur_rst;
        len++;
      end
    end
  endtask

  // One frame: start, 8 data bits LSB first, stop; optional 1-clk glitch mid data bit gl
  task automatic frame(input logic [7:0] b, input bit stop, input int gl);
    put(1'b0, CPB);
    for (int k = 0; k < PB; k++) begin
      if (k == gl) begin
        put(b[k], 4); put(~b[k], 1); put(b[k], CPB - 5);
      end else begin
        put(b[k], CPB);
      end
    end
    put(stop, CPB);
  endtask

  // Synchronised line value seen at posedge e (two flops, forced high by reset)
  function automatic bit meta_v(input int i);
    if (i < 1) return 1'b1;
    if (s_rst[i] || s_rst[i-1]) return 1'b1;
    return s_line[i-1];
  endfunction

  function automatic bit rs_at(input int e);
    int i = e - 1;
    if (i < 1) return 1'b1;
    if (s_rst[i] || s_rst[i-1]) return 1'b1;
    return meta_v(i - 1);
  endfunction

  function automatic bit sample_at(input int e);
`ifdef UART_RX_MAJORITY_EN
    int ones = int'(rs_at(e)) + int'(rs_at(e-1)) + int'(rs_at(e-2));
    return ones >= 2;
`else
    return rs_at(e);
`endif
  endfunction

  function automatic int first_reset(input int a, input int b);
    for (int i = a; i <= b; i++) if (i < len && s_rst[i]) return i;
    return -1;
  endfunction

  // Frame search over the whole script: find each start edge D, derive every sample edge
  // arithmetically, and record the resulting strobe at the stop sample edge.
  task automatic build_model;
    int e, d, ss, sp, r;
    logic [7:0] b;
    logic [7:0] cur;
    e = 1;
    while (e < len) begin
      if (s_rst[e-1] || s_rst[e] || !s_en[e-1] || rs_at(e)) begin
        e++;
        continue;
      end
      d  = e;
      ss = d + HALF;
      sp = d + HALF + (PB + 1) * CPB;
      if (sp >= len) break;
      r = first_reset(d, ss);
      if (r >= 0) begin e = r + 1; continue; end
      if (sample_at(ss)) begin e = ss + 1; continue; end
      r = first_reset(d, sp);
      if (r >= 0) begin e = r + 1; continue; end
      for (int k = 0; k < PB; k++) b[k] = sample_at(d + HALF + (k + 1) * CPB);
      if (sample_at(sp)) begin
        ev_v[sp] = 1'b1; ev_d[sp] = b;
        e = sp + 1;
      end else begin
        ev_f[sp] = 1'b1;
        e = sp + 1;
        while (e < len) begin
          if (s_rst[e-1] || s_rst[e]) break;
          if (rs_at(e)) begin e++; break; end
          e++;
        end
      end
    end
    cur = 8'h00;
    for (int i = 0; i < len; i++) begin
      if (s_rst[i] || (i > 0 && s_rst[i-1])) begin
        e_valid[i] = 1'b0; e_ferr[i] = 1'b0; cur = 8'h00;
      end else begin
        if (ev_v[i]) cur = ev_d[i];
        e_valid[i] = ev_v[i]; e_ferr[i] = ev_f[i];
      end
      e_data[i] = cur;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int strobes(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(d_valid[i]) + int'(d_ferr[i]);
    return n;
  endfunction

  initial begin
    // Reset mid-stream, then a long idle line
    put(1'b1, 3);
    cur_rst = 1'b0; cur_en = 1'b1;
    put(1'b1, 6);
    put(1'b0, 9); put(1'b1, 9); put(1'b0, 9); put(1'b1, 5);
    cur_rst = 1'b1; put(1'b1, 4); cur_rst = 1'b0;
    m_idle = len; put(1'b1, 200);
    // Single good frame
    m_a5 = len; frame(8'hA5, 1'b1, -1); put(1'b1, 20);
    // Back-to-back frames
    m_00 = len; frame(8'h00, 1'b1, -1); frame(8'hFF, 1'b1, -1); put(1'b1, 20);
    // Framing error followed by a held-low line
    m_55 = len; frame(8'h55, 1'b0, -1); put(1'b0, 40); put(1'b1, 60);
    // Short low pulse, then a good frame
    m_short = len; put(1'b0, 2); put(1'b1, 30);
    m_3c1 = len; frame(8'h3C, 1'b1, -1); put(1'b1, 10);
    // Reset during bit 3; enable held low for the rest so the tail bits cannot start a frame
    m_rf = len; frame(8'h3C, 1'b1, -1);
    for (int i = m_rf + 36; i < m_rf + 90; i++) s_en[i] = 1'b0;
    for (int i = m_rf + 39; i < m_rf + 42; i++) s_rst[i] = 1'b1;
    put(1'b1, 10);
    m_3c2 = len; frame(8'h3C, 1'b1, -1); put(1'b1, 20);
    // Glitch at data bit 2 sample point
    m_f0 = len; frame(8'hF0, 1'b1, 2); put(1'b1, 20);
    // Randomised traffic
    for (int f = 0; f < 45 && len < N - 300; f++) begin
      int st, gap;
      cur_en = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 7) == 0) begin
        put(1'b0, $urandom_range(1, 6)); put(1'b1, $urandom_range(1, 12));
      end
      st = len;
      if ($urandom_range(0, 7) == 0) begin
        frame(8'($urandom_range(0, 255)), 1'b0, -1);
        put(1'b0, $urandom_range(0, 20));
      end else begin
        frame(8'($urandom_range(0, 255)), 1'b1,
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, PB - 1) : -1);
      end
      if ($urandom_range(0, 11) == 0) begin
        int ro = st + $urandom_range(0, 85);
        for (int i = ro; i < ro + 3 && i < len; i++) s_rst[i] = 1'b1;
      end
      gap = $urandom_range(0, 12);
      put(1'b1, gap);
    end
    cur_en = 1'b1;
    put(1'b1, 30);

    build_model();

    // Hand-computed anchors for the model: D = fall+3, strobe visible 85 clks after D
    chk("model_a5_valid", int'(e_valid[m_a5 + 88]), 1);
    chk("model_a5_data", int'(e_data[m_a5 + 88]), 8'hA5);
    chk("model_55_ferr", int'(e_ferr[m_55 + 88]), 1);

    // Replay the script and compare every cycle
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      rst_n = !s_rst[i]; uart_rxd = s_line[i]; uart_rx_en = s_en[i];
      @(negedge clk);
      d_valid[i] = uart_rx_valid; d_ferr[i] = uart_rx_ferr; d_data[i] = uart_rx_data;
      checks++;
      if (uart_rx_valid !== e_valid[i] || uart_rx_ferr !== e_ferr[i] ||
          uart_rx_data !== e_data[i] || (uart_rx_valid && uart_rx_ferr)) begin
        errors++;
        if (fail_prints < 30) begin
          fail_prints++;
          $display("FAIL cycle %0d: valid=%b ferr=%b data=%02h, expected valid=%b ferr=%b data=%02h",
                   i, uart_rx_valid, uart_rx_ferr, uart_rx_data, e_valid[i], e_ferr[i], e_data[i]);
        end
      end
    end

    // Directed literal expectations on the recorded DUT outputs
    chk("reset_data", int'(d_data[m_idle]), 8'h00);
    chk("idle_no_strobe", strobes(m_idle, m_idle + 199), 0);
    chk("idle_data", int'(d_data[m_idle + 199]), 8'h00);
    chk("a5_valid", int'(d_valid[m_a5 + 88]), 1);
    chk("a5_data", int'(d_data[m_a5 + 88]), 8'hA5);
    chk("a5_single", strobes(m_a5, m_a5 + 105), 1);
    chk("b2b_00", int'({d_valid[m_00 + 88], d_data[m_00 + 88]}), 9'h100);
    chk("b2b_ff", int'({d_valid[m_00 + 178], d_data[m_00 + 178]}), 9'h1FF);
    chk("ferr_55", int'(d_ferr[m_55 + 88]), 1);
    chk("ferr_keep_data", int'(d_data[m_55 + 88]), 8'hFF);
    chk("ferr_only", strobes(m_55, m_short - 1), 1);
    chk("short_no_strobe", strobes(m_short, m_3c1 - 1), 0);
    chk("3c_first", int'({d_valid[m_3c1 + 88], d_data[m_3c1 + 88]}), 9'h13C);
    chk("rst_frame_dropped", strobes(m_rf, m_3c2 - 1), 0);
    chk("3c_after_rst", int'({d_valid[m_3c2 + 88], d_data[m_3c2 + 88]}), 9'h13C);
`ifdef UART_RX_MAJORITY_EN
    chk("glitch_f0", int'({d_valid[m_f0 + 88], d_data[m_f0 + 88]}), 9'h1F0);
`else
    chk("glitch_f0", int'({d_valid[m_f0 + 88], d_data[m_f0 + 88]}), 9'h1F4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
